// File: rtl/pipe_pkg.sv
// Shared codes for the execute stage: ALU ops, multi-cycle ops, FSM states.
package pipe_pkg;
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIVU = 2'b10;
    localparam logic [1:0] MD_REMU = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] RA_REG = 5'd31;

    // ADD and SUB ignore bit 3 and share 00 in the low bits.
    function automatic logic is_addsub(input logic [3:0] aluc);
        return aluc[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/pipe_exe_stage_if.sv
// ID/EXE-to-EXE/MEM signal bundle for the execute stage.
// EXE_OVERFLOW_EN adds the eovf signal.
interface pipe_exe_stage_if #(parameter int DW = 32);
    logic [DW-1:0] ea, eb, eimm, epc4;
    logic [3:0]    eAluc;
    logic          eAluimm, eshift, ejal;
    logic [1:0]    emd;
    logic          ewreg, em2reg, ewmem;
    logic [4:0]    eRn0;
    logic [DW-1:0] ealu;
    logic [4:0]    ern;
    logic          ewreg_o, em2reg_o, ewmem_o, estall;
`ifdef EXE_OVERFLOW_EN
    logic          eovf;

    modport master(
        output ea, eb, eimm, epc4, eAluc, eAluimm, eshift, ejal, emd,
               ewreg, em2reg, ewmem, eRn0,
        input  ealu, ern, ewreg_o, em2reg_o, ewmem_o, estall, eovf
    );
    modport slave(
        input  ea, eb, eimm, epc4, eAluc, eAluimm, eshift, ejal, emd,
               ewreg, em2reg, ewmem, eRn0,
        output ealu, ern, ewreg_o, em2reg_o, ewmem_o, estall, eovf
    );
`else
    modport master(
        output ea, eb, eimm, epc4, eAluc, eAluimm, eshift, ejal, emd,
               ewreg, em2reg, ewmem, eRn0,
        input  ealu, ern, ewreg_o, em2reg_o, ewmem_o, estall
    );
    modport slave(
        input  ea, eb, eimm, epc4, eAluc, eAluimm, eshift, ejal, emd,
               ewreg, em2reg, ewmem, eRn0,
        output ealu, ern, ewreg_o, em2reg_o, ewmem_o, estall
    );
`endif
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative radix-2 unit: shift-add MUL (low half) and restoring DIVU/REMU.
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result
);
    localparam int MD_CNT_W = $clog2(DW);
    localparam logic [MD_CNT_W-1:0] LAST = MD_CNT_W'(DW - 1);

    md_state_e         state;
    logic [MD_CNT_W-1:0] count;
    logic [1:0]        op_q;
    // acc: product / remainder; x: multiplier / dividend->quotient; y: multiplicand / divisor
    logic [DW-1:0]     acc, x, y;
    logic [DW-1:0]     acc_n, x_n, y_n;
    logic [DW:0]       part, diff;

    always_comb begin
        acc_n = acc;
        x_n   = x;
        y_n   = y;
        part  = {acc, x[DW-1]};
        diff  = part - {1'b0, y};
        if (op_q == MD_MUL) begin
            acc_n = x[0] ? acc + y : acc;
            x_n   = x >> 1;
            y_n   = y << 1;
        end else if (part >= {1'b0, y}) begin
            acc_n = diff[DW-1:0];
            x_n   = {x[DW-2:0], 1'b1};
        end else begin
            acc_n = part[DW-1:0];
            x_n   = {x[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            count  <= '0;
            op_q   <= MD_NONE;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            result <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    op_q  <= op;
                    count <= '0;
                    acc   <= '0;
                    x     <= (op == MD_MUL) ? b : a;
                    y     <= (op == MD_MUL) ? a : b;
                    state <= MD_BUSY;
                end
                MD_BUSY: begin
                    acc <= acc_n;
                    x   <= x_n;
                    y   <= y_n;
                    if (count == LAST) begin
                        result <= (op_q == MD_DIVU) ? x_n : acc_n;
                        state  <= MD_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state == MD_IDLE && start) || state == MD_BUSY;
    assign done = state == MD_DONE;
endmodule

// File: rtl/pipe_exe_stage.sv
// Execute stage: single-cycle ALU, jal override, multi-cycle MUL/DIVU/REMU with stall.
// EXE_OVERFLOW_EN adds eovf and suppresses the register write on ADD/SUB overflow.
module pipe_exe_stage
    import pipe_pkg::*;
#(
    parameter int DW = 32
) (
    input logic             clock,
    input logic             reset,
    pipe_exe_stage_if.slave bus
);
    logic [DW-1:0]        a, b, sum, dif, alu_out, md_result, md_out;
    logic signed [DW-1:0] sra;
    logic [4:0]           sh;
    logic                 md_busy, md_done, md_sel, ovf;

    assign a   = bus.eshift ? {{(DW-5){1'b0}}, bus.eimm[10:6]} : bus.ea;
    assign b   = bus.eAluimm ? bus.eimm : bus.eb;
    assign sh  = a[4:0];
    assign sum = a + b;
    assign dif = a - b;
    assign sra = $signed(b) >>> sh;

    // Bit 3 only distinguishes SRL from SRA; the other ops decode on [2:0].
    always_comb begin
        alu_out = sum;
        case (bus.eAluc[2:0])
            ALUC_ADD[2:0]: alu_out = sum;
            ALUC_SUB[2:0]: alu_out = dif;
            ALUC_AND[2:0]: alu_out = a & b;
            ALUC_OR[2:0]:  alu_out = a | b;
            ALUC_XOR[2:0]: alu_out = a ^ b;
            ALUC_LUI[2:0]: alu_out = DW'({b[15:0], 16'h0});
            ALUC_SLL[2:0]: alu_out = b << sh;
            ALUC_SRL[2:0]: alu_out = bus.eAluc[3] ? sra : b >> sh;
        endcase
    end

    assign md_sel = bus.emd != MD_NONE;

    pipe_muldiv #(.DW(DW)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .start  (md_sel),
        .op     (bus.emd),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // The bubble sent down while busy carries a quiet zero instead of a stale result.
    assign md_out = md_done ? md_result : '0;

`ifdef EXE_OVERFLOW_EN
    assign ovf = is_addsub(bus.eAluc) & ~bus.ejal & ~md_sel &
                 (bus.eAluc[2] ? (a[DW-1] != b[DW-1] && dif[DW-1] != a[DW-1])
                               : (a[DW-1] == b[DW-1] && sum[DW-1] != a[DW-1]));
    assign bus.eovf = ovf;
`else
    assign ovf = 1'b0;
`endif

    assign bus.estall   = md_busy;
    assign bus.ealu     = bus.ejal ? bus.epc4 + DW'(4) : (md_sel ? md_out : alu_out);
    assign bus.ern      = bus.ejal ? RA_REG : bus.eRn0;
    assign bus.ewreg_o  = bus.ewreg & ~md_busy & ~ovf;
    assign bus.em2reg_o = bus.em2reg & ~md_busy;
    assign bus.ewmem_o  = bus.ewmem & ~md_busy;
endmodule

// File: doc/pipe_exe_stage.md
Name: pipe_exe_stage

Overview:
- Execute stage of the 5-stage pipeline. It consumes the ID/EXE register outputs and produces the ALU result, the destination register number, and the gated write controls for the EXE/MEM register.
- Single-cycle ALU ops complete combinationally.
- Multiply, divide and remainder run on an internal iterative unit. While it is busy, the stage asserts estall, which freezes the PC, IF/ID and ID/EXE registers and sends a bubble into EXE/MEM.

Parameters:
- DW, 32, datapath width. MD_CNT_W is derived as clog2(DW).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ea, eb  in  32  register operands.
- eimm  in  32  extended immediate; bits [10:6] are the shift amount.
- epc4  in  32  PC+4 of the instruction.
- eAluc  in  4  ALU op: x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR, x110 LUI, 0011 SLL, 0111 SRL, 1111 SRA.
- eAluimm  in  1  selects eimm as operand B.
- eshift  in  1  selects zero-extended eimm[10:6] as operand A.
- ejal  in  1  jal: result is epc4+4, destination is r31.
- emd  in  2  multi-cycle op: 00 none, 01 MUL (low DW bits, unsigned), 10 DIVU quotient, 11 REMU.
- ewreg, em2reg, ewmem  in  1  control bits passed through.
- eRn0  in  5  destination register before the jal override.
- ealu  out  32  stage result.
- ern  out  5  final destination register.
- ewreg_o, em2reg_o, ewmem_o  out  1  gated controls to EXE/MEM.
- estall  out  1  freeze upstream registers and bubble EXE/MEM.

Behaviour:
- Operand selection:
  - A = eshift ? {27'b0, eimm[10:6]} : ea.
  - B = eAluimm ? eimm : eb.
  - All arithmetic is modulo 2^DW.
  - LUI result = {B[15:0], 16'b0}.
  - Shift amount = A[4:0].
- Result selection: ealu = ejal ? epc4+4 : (emd != 0 ? md_result : alu_out). ern = ejal ? 5'd31 : eRn0.
- Control gating:
  - ewreg_o = ewreg & ~estall.
  - ewmem_o = ewmem & ~estall.
  - em2reg_o = em2reg & ~estall.
- Multi-cycle FSM, states IDLE / BUSY / DONE:
  - IDLE with emd == 0: estall = 0, stays IDLE.
  - IDLE with emd != 0: estall = 1 combinationally in the same cycle. On the clock edge it latches A, B and the op, clears count, and goes to BUSY.
  - BUSY: one radix-2 step per cycle (shift-add for MUL, restoring for DIVU/REMU). estall = 1. When count == DW-1 it goes to DONE; otherwise count increments.
  - DONE: md_result holds the registered result and estall = 0, so the instruction leaves EXE on this edge. Always returns to IDLE.
- Latency: for DW = 32 the stage stalls for 33 cycles and the result appears in the 34th cycle.
- Back-to-back multi-cycle ops: the following instruction arrives in IDLE and restarts normally.
- Divide by zero: quotient = all ones, remainder = dividend. No trap.
- emd changing during BUSY is ignored, because ID/EXE is frozen.
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE; count, latched operands and md_result go to 0.
  - The aborted operation is discarded.
  - Outputs then follow their inputs combinationally. estall = 0 provided emd is 0 after reset, which holds because ID/EXE also resets.

Optional Feature:
- EXE_OVERFLOW_EN defined:
  - Adds output eovf (1 bit), set on signed overflow of ADD/SUB (x000/x100) when ejal = 0 and emd = 0.
  - When eovf = 1, ewreg_o is forced to 0.
- Undefined: no eovf port; ADD/SUB wrap silently.

Decomposition:
- Shared package pipe_pkg holds:
  - ALUC_* codes (4-bit);
  - MD_NONE / MD_MUL / MD_DIVU / MD_REMU (2-bit);
  - MD_IDLE / MD_BUSY / MD_DONE state encodings;
  - RA_REG = 5'd31.
- One sub-module, pipe_muldiv, holds the FSM, counter and iterative datapath. Interface: start, op, a, b → busy, done, result.
- The ALU and muxes stay in pipe_exe_stage.

Test Plan:
- ADD: ea=0x7FFFFFFF, eb=1, eAluc=0000 → ealu=0x80000000, estall=0. With EXE_OVERFLOW_EN: eovf=1 and ewreg_o=0.
- SRA: eshift=1, eimm[10:6]=4, eb=0xF0000000, eAluc=1111 → ealu=0xFF000000. jal with epc4=0x100 → ealu=0x104, ern=31.
- MUL: ea=0x12345, eb=0x100, emd=01, ewreg=1 → estall high 33 cycles, ewreg_o=0 throughout; 34th cycle ealu=0x01234500, ewreg_o=1.
- DIVU 100/7 → quotient 14. REMU 100/7 → remainder 2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Each 33-cycle stall. Back-to-back MUL then DIVU → 66 total stall cycles.
- Reset asserted at BUSY count 10 → estall=0 and FSM in IDLE immediately. After release, a fresh MUL 3×4 → 12 after the full latency.
